open_riscv_soc: RTL and testbench



---
 rtl/open_riscv_soc.sv | 224 ++++++++++++++++++++++
 tb/tb_open_riscv_soc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/open_riscv_soc.sv
// Minimal RV32I SoC: 3-stage core (IF / ID / EX-WB) fetching from a word-addressed ROM.
// Results are only visible in the core register file.

module open_riscv_rom (
  input  logic [11:0] addr,
  output logic [31:0] data
);
  logic [31:0] rom_mem [0:4095];

  assign data = rom_mem[addr];
endmodule

module open_riscv_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] regs [0:31];

  // register array: cleared by reset, x0 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // read ports with same-cycle bypass of the EX write
  always_comb begin
    rdata1 = 32'd0;
    rdata2 = 32'd0;
    if (raddr1 == 5'd0) rdata1 = 32'd0;
    else if (we && (waddr == raddr1)) rdata1 = wdata;
    else rdata1 = regs[raddr1];
    if (raddr2 == 5'd0) rdata2 = 32'd0;
    else if (we && (waddr == raddr2)) rdata2 = wdata;
    else rdata2 = regs[raddr2];
  end
endmodule

module open_risc_v (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_data
);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_REG = 7'b0110011;
  localparam logic [6:0]  OP_LUI = 7'b0110111;
  localparam logic [6:0]  OP_BR  = 7'b1100011;
  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [6:0]  OP_JLR = 7'b1100111;
  localparam logic [6:0]  F7_ALT = 7'b0100000;

  logic [31:0] pc_r, ifid_instr_r, ifid_pc_r;
  logic [6:0]  ex_op_r, ex_f7_r;
  logic [2:0]  ex_f3_r;
  logic [4:0]  ex_rd_r;
  logic [31:0] ex_a_r, ex_b_r, ex_imm_r, ex_pc_r;

  logic [31:0] id_rs1_s, id_rs2_s, id_imm_s;
  logic [31:0] opnd_b_s, alu_res_s, wdata_s, target_s;
  logic        alu_ok_s, br_ok_s, br_taken_s, wen_s, redirect_s;
  logic [4:0]  shamt_s;

  assign rom_addr = pc_r[13:2];

  open_riscv_regfile regs_inst (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (ifid_instr_r[19:15]),
    .raddr2 (ifid_instr_r[24:20]),
    .rdata1 (id_rs1_s),
    .rdata2 (id_rs2_s),
    .we     (wen_s),
    .waddr  (ex_rd_r),
    .wdata  (wdata_s)
  );

  // immediate formation for the instruction in ID
  always_comb begin
    id_imm_s = 32'd0;
    case (ifid_instr_r[6:0])
      OP_IMM, OP_JLR: id_imm_s = {{20{ifid_instr_r[31]}}, ifid_instr_r[31:20]};
      OP_BR:  id_imm_s = {{19{ifid_instr_r[31]}}, ifid_instr_r[31], ifid_instr_r[7],
                          ifid_instr_r[30:25], ifid_instr_r[11:8], 1'b0};
      OP_JAL: id_imm_s = {{11{ifid_instr_r[31]}}, ifid_instr_r[31], ifid_instr_r[19:12],
                          ifid_instr_r[20], ifid_instr_r[30:21], 1'b0};
      OP_LUI: id_imm_s = {ifid_instr_r[31:12], 12'd0};
      default: id_imm_s = 32'd0;
    endcase
  end

  // EX: ALU, branch compare, write-back and redirect control
  always_comb begin
    opnd_b_s   = (ex_op_r == OP_REG) ? ex_b_r : ex_imm_r;
    shamt_s    = opnd_b_s[4:0];
    alu_res_s  = 32'd0;
    // for OP-IMM the funct7 field is immediate bits, so it only constrains shifts
    alu_ok_s   = (ex_op_r == OP_IMM) || (ex_f7_r == 7'd0);
    br_ok_s    = 1'b1;
    br_taken_s = 1'b0;
    wen_s      = 1'b0;
    wdata_s    = 32'd0;
    redirect_s = 1'b0;
    target_s   = ex_pc_r + ex_imm_r;
    case (ex_f3_r)
      3'b000: begin
        if ((ex_op_r == OP_REG) && (ex_f7_r == F7_ALT)) alu_res_s = ex_a_r - opnd_b_s;
        else alu_res_s = ex_a_r + opnd_b_s;
        alu_ok_s = (ex_op_r == OP_IMM) || (ex_f7_r == 7'd0) || (ex_f7_r == F7_ALT);
      end
      3'b001: begin
        alu_res_s = ex_a_r << shamt_s;
        alu_ok_s  = (ex_f7_r == 7'd0);
      end
      3'b010: alu_res_s = {31'd0, $signed(ex_a_r) < $signed(opnd_b_s)};
      3'b011: alu_res_s = {31'd0, ex_a_r < opnd_b_s};
      3'b100: alu_res_s = ex_a_r ^ opnd_b_s;
      3'b101: begin
        if (ex_f7_r == F7_ALT) alu_res_s = $unsigned($signed(ex_a_r) >>> shamt_s);
        else alu_res_s = ex_a_r >> shamt_s;
        alu_ok_s = (ex_f7_r == 7'd0) || (ex_f7_r == F7_ALT);
      end
      3'b110: alu_res_s = ex_a_r | opnd_b_s;
      3'b111: alu_res_s = ex_a_r & opnd_b_s;
      default: alu_res_s = 32'd0;
    endcase
    case (ex_f3_r)
      3'b000: br_taken_s = (ex_a_r == ex_b_r);
      3'b001: br_taken_s = (ex_a_r != ex_b_r);
      3'b100: br_taken_s = ($signed(ex_a_r) < $signed(ex_b_r));
      3'b101: br_taken_s = ($signed(ex_a_r) >= $signed(ex_b_r));
      3'b110: br_taken_s = (ex_a_r < ex_b_r);
      3'b111: br_taken_s = (ex_a_r >= ex_b_r);
      default: br_ok_s = 1'b0;
    endcase
    case (ex_op_r)
      OP_IMM, OP_REG: begin
        wen_s   = alu_ok_s;
        wdata_s = alu_res_s;
      end
      OP_LUI: begin
        wen_s   = 1'b1;
        wdata_s = ex_imm_r;
      end
      OP_JAL: begin
        wen_s      = 1'b1;
        wdata_s    = ex_pc_r + 32'd4;
        redirect_s = 1'b1;
      end
      OP_JLR: begin
        if (ex_f3_r == 3'b000) begin
          wen_s      = 1'b1;
          wdata_s    = ex_pc_r + 32'd4;
          redirect_s = 1'b1;
          target_s   = (ex_a_r + ex_imm_r) & ~32'd1;
        end else begin
          wen_s = 1'b0;
        end
      end
      OP_BR: redirect_s = br_ok_s && br_taken_s;
      default: wen_s = 1'b0;
    endcase
  end

  // pipeline registers; a redirect flushes IF/ID and ID/EX to NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || redirect_s) begin
      if (!rst_n) pc_r <= 32'd0;
      else pc_r <= target_s;
      ifid_instr_r <= NOP;
      ifid_pc_r    <= 32'd0;
      ex_op_r      <= OP_IMM;
      ex_f3_r      <= 3'd0;
      ex_f7_r      <= 7'd0;
      ex_rd_r      <= 5'd0;
      ex_a_r       <= 32'd0;
      ex_b_r       <= 32'd0;
      ex_imm_r     <= 32'd0;
      ex_pc_r      <= 32'd0;
    end else begin
      pc_r         <= pc_r + 32'd4;
      ifid_instr_r <= rom_data;
      ifid_pc_r    <= pc_r;
      ex_op_r      <= ifid_instr_r[6:0];
      ex_f3_r      <= ifid_instr_r[14:12];
      ex_f7_r      <= ifid_instr_r[31:25];
      ex_rd_r      <= ifid_instr_r[11:7];
      ex_a_r       <= id_rs1_s;
      ex_b_r       <= id_rs2_s;
      ex_imm_r     <= id_imm_s;
      ex_pc_r      <= ifid_pc_r;
    end
  end
endmodule

module open_riscv_soc (
  input logic clk,
  input logic rst_n
);
  logic [11:0] rom_addr;
  logic [31:0] rom_data;

  open_riscv_rom rom_inst (
    .addr (rom_addr),
    .data (rom_data)
  );

  open_risc_v open_risc_v_inst (
    .clk      (clk),
    .rst_n    (rst_n),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );
endmodule

// File: tb/tb_open_riscv_soc.sv
// Directed-program bench for open_riscv_soc: programs are poked into the ROM
// and results read from the register file through the backdoor hierarchy.

module tb_open_riscv_soc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] prog[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  open_riscv_soc dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] rreg(int i);
    return dut.open_risc_v_inst.regs_inst.regs[i];
  endfunction

  task automatic load_rom();
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = NOP;
    for (int i = 0; i < prog.size(); i++) dut.rom_inst.rom_mem[i] = prog[i];
  endtask

  task automatic start_prog();
    rst_n = 1'b0;
    load_rom();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (rreg(i) !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg x%0d: got %h expected 0", i, rreg(i));
      end
    end
    n_checks++;
    if (dut.open_risc_v_inst.pc_r !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h expected 0", dut.open_risc_v_inst.pc_r);
    end
  endtask

  task automatic add_prog();
    prog.delete();
    prog.push_back(addi(5'd27, 5'd0, 12'd5));
    prog.push_back(addi(5'd28, 5'd0, 12'd7));
    prog.push_back(enc_r(7'd0, 5'd28, 5'd27, 3'b000, 5'd29));
  endtask

  task automatic test_add();
    add_prog();
    start_prog();
    step(2);
    n_checks++;
    if (rreg(27) !== 32'd0) begin
      n_fail++;
      $display("FAIL add_x27_early: got %h expected 0", rreg(27));
    end
    step(1);
    n_checks++;
    if (rreg(27) !== 32'd5) begin
      n_fail++;
      $display("FAIL add_x27_edge3: got %h expected 5", rreg(27));
    end
    step(1);
    n_checks++;
    if (rreg(28) !== 32'd7 || rreg(29) !== 32'd0) begin
      n_fail++;
      $display("FAIL add_edge4: got x28=%h x29=%h expected 7 0", rreg(28), rreg(29));
    end
    step(1);
    n_checks++;
    if (rreg(29) !== 32'd12) begin
      n_fail++;
      $display("FAIL add_x29_edge5: got %h expected c", rreg(29));
    end
  endtask

  task automatic test_back_to_back();
    prog.delete();
    prog.push_back(addi(5'd1, 5'd0, 12'hFFF));
    prog.push_back(addi(5'd1, 5'd1, 12'd1));
    prog.push_back(enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd2));
    prog.push_back(enc_r(7'd0, 5'd1, 5'd0, 3'b011, 5'd3));
    start_prog();
    step(3);
    n_checks++;
    if (rreg(1) !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL b2b_x1_first: got %h expected ffffffff", rreg(1));
    end
    step(5);
    n_checks++;
    if (rreg(1) !== 32'd0 || rreg(2) !== 32'd0 || rreg(3) !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_final: got x1=%h x2=%h x3=%h expected 0 0 0", rreg(1), rreg(2), rreg(3));
    end
  endtask

  task automatic test_signed();
    prog.delete();
    prog.push_back(addi(5'd5, 5'd0, 12'hFF8));
    prog.push_back(enc_i(12'h401, 5'd5, 3'b101, 5'd6, 7'b0010011));
    prog.push_back(enc_i(12'd28, 5'd5, 3'b101, 5'd7, 7'b0010011));
    prog.push_back(enc_r(7'd0, 5'd0, 5'd5, 3'b010, 5'd8));
    start_prog();
    step(8);
    if (rreg(5) !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL signed_x5: got %h expected fffffff8", rreg(5));
    end
    n_checks++;
    if (rreg(6) !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL signed_srai: got %h expected fffffffc", rreg(6));
    end
    n_checks++;
    if (rreg(7) !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL signed_srli: got %h expected f", rreg(7));
    end
    n_checks++;
    if (rreg(8) !== 32'd1) begin
      n_fail++;
      $display("FAIL signed_slt: got %h expected 1", rreg(8));
    end
    n_checks++;
  endtask

  task automatic test_branch_flush();
    prog.delete();
    prog.push_back(addi(5'd1, 5'd0, 12'd1));
    prog.push_back(enc_b(13'd12, 5'd1, 5'd1, 3'b000));
    prog.push_back(addi(5'd2, 5'd0, 12'd9));
    prog.push_back(addi(5'd3, 5'd0, 12'd9));
    prog.push_back(addi(5'd4, 5'd0, 12'd4));
    start_prog();
    step(10);
    n_checks++;
    if (rreg(2) !== 32'd0 || rreg(3) !== 32'd0) begin
      n_fail++;
      $display("FAIL branch_flushed: got x2=%h x3=%h expected 0 0", rreg(2), rreg(3));
    end
    n_checks++;
    if (rreg(4) !== 32'd4) begin
      n_fail++;
      $display("FAIL branch_target: got %h expected 4", rreg(4));
    end
  endtask

  task automatic test_jal_x0();
    prog.delete();
    prog.push_back(enc_j(21'd8, 5'd10));
    prog.push_back(addi(5'd11, 5'd0, 12'd3));
    prog.push_back(addi(5'd0, 5'd0, 12'd5));
    start_prog();
    step(10);
    n_checks++;
    if (rreg(10) !== 32'd4) begin
      n_fail++;
      $display("FAIL jal_link: got %h expected 4", rreg(10));
    end
    n_checks++;
    if (rreg(11) !== 32'd0) begin
      n_fail++;
      $display("FAIL jal_flush: got %h expected 0", rreg(11));
    end
    n_checks++;
    if (rreg(0) !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_write: got %h expected 0", rreg(0));
    end
  endtask

  task automatic test_jalr_lui_cmp();
    prog.delete();
    prog.push_back(addi(5'd1, 5'd0, 12'd2));                       // 0
    prog.push_back(enc_b(13'd8, 5'd1, 5'd1, 3'b001));              // 4: bne not taken
    prog.push_back(addi(5'd2, 5'd0, 12'd6));                       // 8
    prog.push_back(enc_i(12'd19, 5'd1, 3'b000, 5'd3, 7'b1100111)); // 12: jalr -> 20
    prog.push_back(addi(5'd5, 5'd0, 12'd7));                       // 16 flushed
    prog.push_back(addi(5'd6, 5'd0, 12'd8));                       // 20
    prog.push_back({20'h12345, 5'd7, 7'b0110111});                 // 24: lui
    prog.push_back(addi(5'd8, 5'd0, 12'hFFF));                     // 28
    prog.push_back(enc_b(13'd8, 5'd8, 5'd1, 3'b110));              // 32: bltu taken
    prog.push_back(addi(5'd9, 5'd0, 12'd1));                       // 36 flushed
    prog.push_back(enc_b(13'd8, 5'd1, 5'd8, 3'b100));              // 40: blt taken
    prog.push_back(addi(5'd10, 5'd0, 12'd1));                      // 44 flushed
    prog.push_back(addi(5'd11, 5'd0, 12'd3));                      // 48
    start_prog();
    step(30);
    n_checks++;
    if (rreg(2) !== 32'd6) begin
      n_fail++;
      $display("FAIL bne_not_taken: got %h expected 6", rreg(2));
    end
    n_checks++;
    if (rreg(3) !== 32'd16 || rreg(5) !== 32'd0 || rreg(6) !== 32'd8) begin
      n_fail++;
      $display("FAIL jalr: got x3=%h x5=%h x6=%h expected 10 0 8", rreg(3), rreg(5), rreg(6));
    end
    n_checks++;
    if (rreg(7) !== 32'h1234_5000) begin
      n_fail++;
      $display("FAIL lui: got %h expected 12345000", rreg(7));
    end
    n_checks++;
    if (rreg(9) !== 32'd0 || rreg(10) !== 32'd0 || rreg(11) !== 32'd3) begin
      n_fail++;
      $display("FAIL bltu_blt: got x9=%h x10=%h x11=%h expected 0 0 3", rreg(9), rreg(10), rreg(11));
    end
  endtask

  task automatic test_reset_mid_run();
    add_prog();
    start_prog();
    step(4);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rreg(27) !== 32'd0 || rreg(28) !== 32'd0 || dut.open_risc_v_inst.pc_r !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_clear: got x27=%h x28=%h pc=%h expected 0 0 0",
               rreg(27), rreg(28), dut.open_risc_v_inst.pc_r);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    n_checks++;
    if (rreg(29) !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_x29_early: got %h expected 0", rreg(29));
    end
    step(1);
    n_checks++;
    if (rreg(29) !== 32'd12) begin
      n_fail++;
      $display("FAIL midrst_rerun: got %h expected c", rreg(29));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_signed();
    test_branch_flush();
    test_jal_x0();
    test_jalr_lui_cmp();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
